// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, polarity normalisation and
// counter-based debounce with a clean level plus one-cycle press/release strobes.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Raw pad value that corresponds to "released"; sync FFs reset to it.
   localparam logic            RAW_REL = ACTIVE_LOW ? 1'b1 : 1'b0;

   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_PRESSED      = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   logic             sync1_q, sync2_q;
   logic             pressed_c;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;

   // Two-stage synchroniser for the asynchronous pad input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= RAW_REL;
         sync2_q <= RAW_REL;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Normalised synced sample: 1 = pressed regardless of pad polarity.
   assign pressed_c = ACTIVE_LOW ? ~sync2_q : sync2_q;

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // Next-state logic: any opposite sample in a WAIT state aborts qualification.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pressed_c) begin
               state_d = ST_PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!pressed_c) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_PRESSED: begin
            if (!pressed_c) begin
               state_d = ST_RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         ST_RELEASE_WAIT: begin
            if (pressed_c) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule
